// File: rtl/preproc_seq.sv
// preproc_seq: moves one block of len samples from a show-ahead FIFO into the DFT
// input register, with valid/ready handshake, sop/eop framing, stall counting and abort/flush.
`ifndef FFT_IN_WIDTH
`define FFT_IN_WIDTH 16
`endif

module preproc_seq #(
  parameter int DATA_WIDTH = 2*`FFT_IN_WIDTH,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  output logic                  fifo_re_o,
  output logic                  fifo_clr_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  len_err_o,
  output logic [15:0]           stall_cnt_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_rdCnt;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_doutValid;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_fifoClr;
  logic                  r_lenErr;
  logic [15:0]           r_stallCnt;

  logic w_outFree;
  logic w_moreToRead;
  logic w_pop;
  logic w_stall;
  logic w_accept;
  logic w_startOk;
  logic w_eopHit;
  logic w_lastPop;

  // The output register is free when empty or being drained this cycle; abort blocks any pop.
  assign w_outFree    = !r_doutValid || dout_ready_i;
  assign w_moreToRead = (r_rdCnt != r_len);
  assign w_pop        = (r_state == S_RUN) && !abort_i && !r_fifoClr && !fifo_empty_i
                        && w_outFree && w_moreToRead;
  assign w_stall      = (r_state == S_RUN) && !abort_i && fifo_empty_i && w_outFree && w_moreToRead;
  assign w_accept     = r_doutValid && dout_ready_i;
  assign w_startOk    = (r_state == S_IDLE) && start_i && !abort_i && (len_i != '0);
  assign w_eopHit     = (r_rdCnt == (r_len - LEN_ONE));
  assign w_lastPop    = w_pop && w_eopHit;

  assign fifo_re_o    = w_pop;
  assign fifo_clr_o   = r_fifoClr;
  assign dout_o       = r_dout;
  assign dout_valid_o = r_doutValid;
  assign sop_o        = r_sop;
  assign eop_o        = r_eop;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign len_err_o    = r_lenErr;
  assign stall_cnt_o  = r_stallCnt;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_rdCnt     <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_fifoClr   <= 1'b0;
      r_lenErr    <= 1'b0;
      r_stallCnt  <= '0;
    end else begin
      r_fifoClr <= abort_i;
      r_lenErr  <= (r_state == S_IDLE) && start_i && !abort_i && (len_i == '0);
      if (abort_i) begin
        r_state     <= S_IDLE;
        r_doutValid <= 1'b0;
        r_sop       <= 1'b0;
        r_eop       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_startOk) begin
              r_len      <= len_i;
              r_rdCnt    <= '0;
              r_stallCnt <= '0;
              r_state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (w_lastPop) r_state <= S_DRAIN;
          end
          // Only the eop word can be in flight here, so its handshake ends the block.
          S_DRAIN: begin
            if (w_accept) r_state <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase

        if (w_pop) begin
          r_dout      <= fifo_dout_i;
          r_doutValid <= 1'b1;
          r_sop       <= (r_rdCnt == '0);
          r_eop       <= w_eopHit;
          r_rdCnt     <= r_rdCnt + LEN_ONE;
        end else if (w_accept) begin
          r_doutValid <= 1'b0;
          r_sop       <= 1'b0;
          r_eop       <= 1'b0;
        end

        if (w_stall && (r_stallCnt != 16'hFFFF)) r_stallCnt <= r_stallCnt + 16'd1;
      end
    end
  end

endmodule
